// File: rtl/ifft_dif_butterfly.sv
// ifft_dif_butterfly: 3-stage radix-2 DIF inverse butterfly, out0=(a+b)/2, out1=((a-b)*conj(tw))/2.
// Build option IFFT_BFLY_SAT_EN: saturate out1 when narrowing to W bits (default wraps).
module ifft_dif_butterfly #(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in0_r,
    input  logic [W-1:0] in0_i,
    input  logic [W-1:0] in1_r,
    input  logic [W-1:0] in1_i,
    input  logic [W-1:0] twiddle_r,
    input  logic [W-1:0] twiddle_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out0_r,
    output logic [W-1:0] out0_i,
    output logic [W-1:0] out1_r,
    output logic [W-1:0] out1_i
);
    logic                  v1, v2, v3, adv;
    logic signed [W:0]     sum_r1, sum_i1, diff_r1, diff_i1, sum_r2, sum_i2;
    logic signed [W-1:0]   tw_r1, tw_i1;
    logic signed [2*W:0]   pr1, pr2, pi1, pi2;
    logic signed [2*W+1:0] re_full, im_full;
    logic [W-1:0]          out1_r_n, out1_i_n;

    function automatic logic signed [W:0] ext1(input logic [W-1:0] a);
        return $signed({a[W-1], a});
    endfunction

    function automatic logic signed [2*W:0] xd(input logic signed [W:0] a);
        return $signed({{W{a[W]}}, a});
    endfunction

    function automatic logic signed [2*W:0] xt(input logic signed [W-1:0] a);
        return $signed({{(W+1){a[W-1]}}, a});
    endfunction

    // The whole pipeline moves together whenever the output slot is free or being drained
    assign adv       = ~v3 | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;
    assign re_full   = $signed({pr1[2*W], pr1}) + $signed({pr2[2*W], pr2});
    assign im_full   = $signed({pi1[2*W], pi1}) - $signed({pi2[2*W], pi2});

`ifdef IFFT_BFLY_SAT_EN
    localparam logic signed [2*W+1:0] sat_hi = {{(W+3){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W+1:0] sat_lo = {{(W+3){1'b1}}, {(W-1){1'b0}}};
    logic signed [2*W+1:0] re_sh, im_sh;
    // Scale the cross-product sums and clamp them into the signed W-bit range
    always_comb begin
        re_sh    = re_full >>> (FRAC + 1);
        im_sh    = im_full >>> (FRAC + 1);
        out1_r_n = re_sh > sat_hi ? {1'b0, {(W-1){1'b1}}} : re_sh < sat_lo ? {1'b1, {(W-1){1'b0}}} : W'(re_sh);
        out1_i_n = im_sh > sat_hi ? {1'b0, {(W-1){1'b1}}} : im_sh < sat_lo ? {1'b1, {(W-1){1'b0}}} : W'(im_sh);
    end
`else
    // Scale the cross-product sums and keep the low W bits
    always_comb begin
        out1_r_n = W'(re_full >>> (FRAC + 1));
        out1_i_n = W'(im_full >>> (FRAC + 1));
    end
`endif

    // S1: widened sum/difference of the pair, twiddle captured alongside
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1      <= 1'b0;
            sum_r1  <= '0;
            sum_i1  <= '0;
            diff_r1 <= '0;
            diff_i1 <= '0;
            tw_r1   <= '0;
            tw_i1   <= '0;
        end else if (adv) begin
            v1      <= in_valid;
            sum_r1  <= ext1(in0_r) + ext1(in1_r);
            sum_i1  <= ext1(in0_i) + ext1(in1_i);
            diff_r1 <= ext1(in0_r) - ext1(in1_r);
            diff_i1 <= ext1(in0_i) - ext1(in1_i);
            tw_r1   <= $signed(twiddle_r);
            tw_i1   <= $signed(twiddle_i);
        end
    end

    // S2: full-precision partial products of diff * conj(tw), sum delayed to match
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2     <= 1'b0;
            pr1    <= '0;
            pr2    <= '0;
            pi1    <= '0;
            pi2    <= '0;
            sum_r2 <= '0;
            sum_i2 <= '0;
        end else if (adv) begin
            v2     <= v1;
            pr1    <= xd(diff_r1) * xt(tw_r1);
            pr2    <= xd(diff_i1) * xt(tw_i1);
            pi1    <= xd(diff_i1) * xt(tw_r1);
            pi2    <= xd(diff_r1) * xt(tw_i1);
            sum_r2 <= sum_r1;
            sum_i2 <= sum_i1;
        end
    end

    // S3: halved outputs, held while downstream stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v3     <= 1'b0;
            out0_r <= '0;
            out0_i <= '0;
            out1_r <= '0;
            out1_i <= '0;
        end else if (adv) begin
            v3     <= v2;
            out0_r <= W'(sum_r2 >>> 1);
            out0_i <= W'(sum_i2 >>> 1);
            out1_r <= out1_r_n;
            out1_i <= out1_i_n;
        end
    end
endmodule

// File: doc/ifft_dif_butterfly.md
Name: ifft_dif_butterfly

Overview:
- Pipelined radix-2 decimation-in-frequency inverse butterfly; the inverse-direction counterpart of the forward DIT butterfly (Butterfly2).
- Computes out0 = (in0 + in1)/2 and out1 = ((in0 - in1) * conj(twiddle))/2 on signed fixed-point complex samples.
- Used as the stage element of the 32-point IFFT datapath, between stage buffers, with valid/ready flow control.

Parameters:
- W, 32, data and twiddle word width (signed two's complement).
- FRAC, 16, fractional bits (Q(W-FRAC).FRAC format; 1.0 = 0x00010000 at defaults).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- in_valid  input  1  input sample pair valid.
- in_ready  output  1  block can accept a pair this cycle.
- in0_r, in0_i  input  W  first complex input.
- in1_r, in1_i  input  W  second complex input.
- twiddle_r, twiddle_i  input  W  twiddle factor, sampled with the pair.
- out_valid  output  1  output pair valid.
- out_ready  input  1  downstream accepts output.
- out0_r, out0_i  output  W  (in0+in1)/2.
- out1_r, out1_i  output  W  ((in0-in1)*conj(tw))/2.

Behaviour:
- Reset (rst=0, async): all pipeline valid bits and all data registers clear to 0, so out_valid=0 and all out* = 0 immediately, not at the next edge. in_ready is 1 once reset is released.
- Three register stages S1, S2, S3. S3 drives the outputs.
- Global advance: adv = ~S3.valid | out_ready. in_ready = adv (combinational).
- Transfers: an input transfers when in_valid & in_ready. An output transfers when out_valid & out_ready.
- On adv, every stage loads from its predecessor, with S1.valid <= in_valid. Bubbles propagate as invalid stages.
- When adv=0, all stages and the outputs hold unchanged.
- Latency: 3 cycles from input transfer to out_valid, with no backpressure. Throughput: one pair per cycle.
- S1:
  - sum_r/i = in0 + in1 and diff_r/i = in0 - in1, each (W+1)-bit sign-extended, no overflow.
  - Register the twiddle.
- S2 (four full-precision signed products, 2W+1 bits each):
  - pr1 = diff_r*tw_r
  - pr2 = diff_i*tw_i
  - pi1 = diff_i*tw_r
  - pi2 = diff_r*tw_i
  - Delay sum_r/i alongside.
- S3 (results computed at 2W+2 bits, then narrowed to W):
  - out1_r = (pr1 + pr2) >>> (FRAC+1)
  - out1_i = (pi1 - pi2) >>> (FRAC+1)
  - out0_r/i = sum >>> 1
  - Shifts are arithmetic, i.e. truncation toward negative infinity.
- out0 never overflows. out1 narrowing follows the Optional Feature.
- Output ordering equals input ordering; no sample is dropped or duplicated under any out_ready pattern.
- in_valid while in_ready=0: inputs are ignored. The source must hold them until accepted.
- Reset mid-operation: all in-flight pairs are discarded. After release, the first accepted pair emerges exactly 3 cycles later.

Optional Feature:
- Macro: IFFT_BFLY_SAT_EN.
- Defined: the out1 W-bit narrowing saturates to 0x7FFFFFFF / 0x80000000 (for W=32) when the shifted value exceeds the signed W-bit range.
- Undefined: the low W bits are kept (wrap-around).
- Timing and handshake are identical in both builds.

Test Plan:
- Basic: in0=(0x00010000,0), in1=(0x00010000,0), tw=(0x00010000,0), out_ready=1 -> 3 cycles later out_valid=1, out0=(0x00010000,0), out1=(0,0).
- Conjugate twiddle: in0=(0x00010000,0), in1=(0xFFFF0000,0x00020000), tw=(0,0x00010000) -> diff=(2,-2), product (2-2j)(-j)=(-2,-2), halved -> out1=(0xFFFF0000,0xFFFF0000); out0=(0,0x00010000).
- Backpressure: stream 8 distinct pairs with in_valid=1, hold out_ready=0 for cycles 2-7 -> in_ready falls after 3 pairs are held; once out_ready=1, all 8 results appear in order with no loss or duplicates.
- Reset mid-stream: drop rst to 0 with 3 pairs in flight -> out_valid and all outputs go to 0 without waiting for a clock edge. After release, one pair produces exactly one out_valid pulse 3 cycles later.
- Overflow: in0=(0x7FFFFFFF,0), in1=(0x80000000,0), tw=(0x00020000,0) -> out0_r=0xFFFFFFFF in both builds. out1_r=0x7FFFFFFF with IFFT_BFLY_SAT_EN defined, 0xFFFFFFFF without.
- Bubbles: in_valid toggles every other cycle with out_ready=1 -> out_valid toggles identically, delayed by 3 cycles.
